rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single synchronous graphics/game ROM read port between two requesters: the picture processing unit (tile/sprite pixel fetch) and the game statemachine (level/attribute data).
- Sits between ppu, statemachine and the ROM on the 108 MHz pixel clock.
- PPU has fixed priority, because missed pixel fetches corrupt video. A starvation counter guarantees the statemachine forward progress.
- Tags every in-flight read so each read datum returns only to its owner.

Parameters:
- ADDR_W, 14, ROM address width.
- DATA_W, 16, ROM data width.
- ROM_LAT, 2, ROM read latency in cycles from rom_rd high to rom_q valid (1..4).
- STARVE_MAX, 8, consecutive cycles sm_req may be denied before sm is forced through (>=1).

Ports:
- clock  in  1  system clock (pll output); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ppu_req  in  1  ppu read request; held with ppu_addr stable until granted.
- ppu_addr  in  ADDR_W  ppu read address.
- ppu_gnt  out  1  combinational; request accepted this cycle.
- ppu_valid  out  1  one-cycle pulse; ppu_data valid.
- ppu_data  out  DATA_W  read data for ppu.
- sm_req  in  1  statemachine read request; same rules as ppu_req.
- sm_addr  in  ADDR_W  statemachine read address.
- sm_gnt  out  1  combinational grant to statemachine.
- sm_valid  out  1  one-cycle pulse; sm_data valid.
- sm_data  out  DATA_W  read data for statemachine.
- rom_rd  out  1  registered ROM read strobe.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_rd.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: rom_rd=0, rom_addr=0, ppu_valid=0, sm_valid=0, ppu_data=0, sm_data=0, starve counter=0, tag pipeline cleared, state=NORMAL.
- At most one grant per cycle. A grant is only ever given to an asserted req.
- States:
  - NORMAL: ppu_gnt=ppu_req; sm_gnt=sm_req & ~ppu_req.
  - FORCE_SM: sm_gnt=sm_req; ppu_gnt=0.
- Starve counter:
  - Increments each cycle sm_req=1 and sm_gnt=0, saturating at STARVE_MAX.
  - Clears on sm_gnt or sm_req=0.
- Transitions:
  - NORMAL->FORCE_SM when counter==STARVE_MAX at the clock edge.
  - FORCE_SM->NORMAL after exactly one cycle. This holds even if sm_req dropped; no grant is issued in that case.
- Issue stage: on any grant, rom_rd<=1 and rom_addr<=granted address on the next edge; otherwise rom_rd<=0 and rom_addr holds.
- Tag pipeline: ROM_LAT+1 deep shift of {valid, owner}. Owner 0 = ppu, 1 = sm. The entry is captured at grant.
- Return:
  - When the tag emerges, the owner's *_data<=rom_q and its *_valid pulses for one cycle.
  - Latency is grant cycle to valid cycle = ROM_LAT+1 edges (3 at default).
  - *_data holds its last value between pulses.
- Throughput: back-to-back grants every cycle to either requester. Returns arrive in grant order; no reordering.
- Simultaneous requests: NORMAL grants ppu; FORCE_SM grants sm.
- Reset mid-operation: all in-flight tags are dropped. No *_valid is produced for reads granted before reset, even though the ROM may still return data.
- A requester dropping req before grant is legal; no grant or read results.

Optional Feature:
- Macro ROM_ARB_STATS_EN.
- When defined, adds these outputs, all cleared by reset:
  - stat_ppu_cnt (32) counts ppu grants.
  - stat_sm_cnt (32) counts sm grants.
  - stat_force_cnt (16) counts FORCE_SM entries.
  - stat_max_wait (8) records the maximum consecutive sm denial cycles observed.
- Counters saturate at all-ones.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Defaults. Sequence:
  - reset high 2 cycles, then ppu_req=1, ppu_addr=0x0010 for 1 cycle.
  - Required: ppu_gnt=1 that cycle; rom_rd=1, rom_addr=0x0010 next cycle.
  - Required: ppu_valid=1 with ppu_data=ROM[0x0010] 3 edges after grant; sm_valid stays 0.
- ppu and sm request simultaneously every cycle, sm_addr=0x0200.
  - Required: ppu granted 8 consecutive cycles, then sm_gnt=1 for exactly 1 cycle, then ppu again.
  - Required: pattern repeats; sm_data=ROM[0x0200].
- Alternating single requests ppu 0x1, sm 0x2, ppu 0x3 on consecutive cycles.
  - Required: returns on 3 consecutive cycles to ppu, sm, ppu with correct data in order.
- Grant sm read 0x0005, then assert reset 1 cycle later.
  - Required: no sm_valid ever appears; all outputs at reset values one edge after reset.
- sm_req held 8 cycles under ppu load, then sm_req dropped in the force cycle.
  - Required: no grant that cycle, rom_rd=0, return to NORMAL.
- With ROM_ARB_STATS_EN, run the 2nd scenario for 18 cycles.
  - Required: stat_ppu_cnt=16, stat_sm_cnt=2, stat_force_cnt=2, stat_max_wait=8.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Bus bundle for rom_arbiter: ppu and statemachine read channels plus the ROM read port.
// slave = arbiter side, master = requesters/ROM side.
interface rom_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_gnt;
  logic              ppu_valid;
  logic [DATA_W-1:0] ppu_data;

  logic              sm_req;
  logic [ADDR_W-1:0] sm_addr;
  logic              sm_gnt;
  logic              sm_valid;
  logic [DATA_W-1:0] sm_data;

  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

  modport slave (
    input  ppu_req, ppu_addr, sm_req, sm_addr, rom_q,
    output ppu_gnt, ppu_valid, ppu_data, sm_gnt, sm_valid, sm_data, rom_rd, rom_addr
  );

  modport master (
    output ppu_req, ppu_addr, sm_req, sm_addr, rom_q,
    input  ppu_gnt, ppu_valid, ppu_data, sm_gnt, sm_valid, sm_data, rom_rd, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM read port between ppu (fixed priority) and statemachine (starvation-forced).
// Optional statistics outputs are enabled by defining ROM_ARB_STATS_EN.
module rom_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
`ifdef ROM_ARB_STATS_EN
  output logic [31:0] stat_ppu_cnt,
  output logic [31:0] stat_sm_cnt,
  output logic [15:0] stat_force_cnt,
  output logic [7:0]  stat_max_wait,
`endif
  rom_arbiter_if.slave bus
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {ST_NORMAL, ST_FORCE_SM} state_e;

  typedef struct packed {
    logic valid;
    logic owner;  // 0 = ppu, 1 = sm
  } tag_t;

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_starve, w_starve_next;
  logic              w_ppu_gnt, w_sm_gnt, w_any_gnt;
  logic              r_rom_rd;
  logic [ADDR_W-1:0] r_rom_addr;
  tag_t              r_tag [ROM_LAT];
  logic              r_ppu_valid, r_sm_valid;
  logic [DATA_W-1:0] r_ppu_data, r_sm_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_NORMAL;
    else       r_state <= w_state_next;
  end

  // The force decision looks at the counter value being latched, so the sm slot lands
  // right after the STARVE_MAX-th denial.
  always_comb begin
    w_state_next = ST_NORMAL;
    if (r_state == ST_NORMAL && w_starve_next == STARVE_LIM) w_state_next = ST_FORCE_SM;
  end

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    w_ppu_gnt = 1'b0;
    w_sm_gnt  = 1'b0;
    if (!reset) begin
      unique case (r_state)
        ST_NORMAL: begin
          w_ppu_gnt = bus.ppu_req;
          w_sm_gnt  = bus.sm_req & ~bus.ppu_req;
        end
        ST_FORCE_SM: w_sm_gnt = bus.sm_req;
      endcase
    end
  end

  assign w_any_gnt = w_ppu_gnt | w_sm_gnt;

  always_comb begin
    w_starve_next = '0;
    if (bus.sm_req && !w_sm_gnt)
      w_starve_next = (r_starve == STARVE_LIM) ? r_starve : r_starve + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve   <= '0;
      r_rom_rd   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_starve <= w_starve_next;
      r_rom_rd <= w_any_gnt;
      if (w_any_gnt) r_rom_addr <= w_ppu_gnt ? bus.ppu_addr : bus.sm_addr;
    end
  end

  // Tag shift; the *_valid registers form its final stage. NOTE: the tag array is flops, not
  // RAM, and is cleared on reset so reads in flight at reset never return.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
      r_ppu_valid <= 1'b0;
      r_sm_valid  <= 1'b0;
      r_ppu_data  <= '0;
      r_sm_data   <= '0;
    end else begin
      r_tag[0] <= tag_t'{valid: w_any_gnt, owner: w_sm_gnt};
      for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_ppu_valid <= r_tag[ROM_LAT-1].valid & ~r_tag[ROM_LAT-1].owner;
      r_sm_valid  <= r_tag[ROM_LAT-1].valid &  r_tag[ROM_LAT-1].owner;
      if (r_tag[ROM_LAT-1].valid && !r_tag[ROM_LAT-1].owner) r_ppu_data <= bus.rom_q;
      if (r_tag[ROM_LAT-1].valid &&  r_tag[ROM_LAT-1].owner) r_sm_data  <= bus.rom_q;
    end
  end

  assign bus.ppu_gnt   = w_ppu_gnt;
  assign bus.sm_gnt    = w_sm_gnt;
  assign bus.rom_rd    = r_rom_rd;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.ppu_valid = r_ppu_valid;
  assign bus.sm_valid  = r_sm_valid;
  assign bus.ppu_data  = r_ppu_data;
  assign bus.sm_data   = r_sm_data;

`ifdef ROM_ARB_STATS_EN
  logic [31:0] r_stat_ppu, r_stat_sm, w_wait_ext;
  logic [15:0] r_stat_force;
  logic [7:0]  r_stat_wait, w_wait_clip;

  assign w_wait_ext  = 32'(w_starve_next);
  assign w_wait_clip = (w_wait_ext > 32'd255) ? 8'hFF : w_wait_ext[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_ppu   <= '0;
      r_stat_sm    <= '0;
      r_stat_force <= '0;
      r_stat_wait  <= '0;
    end else begin
      if (w_ppu_gnt && r_stat_ppu != '1) r_stat_ppu <= r_stat_ppu + 1'b1;
      if (w_sm_gnt  && r_stat_sm  != '1) r_stat_sm  <= r_stat_sm + 1'b1;
      if (r_state == ST_NORMAL && w_state_next == ST_FORCE_SM && r_stat_force != '1)
        r_stat_force <= r_stat_force + 1'b1;
      if (w_wait_clip > r_stat_wait) r_stat_wait <= w_wait_clip;
    end
  end

  assign stat_ppu_cnt   = r_stat_ppu;
  assign stat_sm_cnt    = r_stat_sm;
  assign stat_force_cnt = r_stat_force;
  assign stat_max_wait  = r_stat_wait;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random traffic against a
// queue-based scoreboard of expected grants and returns.
module tb_rom_arbiter;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 16;
  localparam int ROM_LAT    = 2;
  localparam int STARVE_MAX = 8;

  typedef struct {
    int               due;
    bit               owner;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ROM_ARB_STATS_EN
  logic [31:0] stat_ppu_cnt, stat_sm_cnt;
  logic [15:0] stat_force_cnt;
  logic [7:0]  stat_max_wait;
`endif

  rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock          (clock),
    .reset          (reset),
`ifdef ROM_ARB_STATS_EN
    .stat_ppu_cnt   (stat_ppu_cnt),
    .stat_sm_cnt    (stat_sm_cnt),
    .stat_force_cnt (stat_force_cnt),
    .stat_max_wait  (stat_max_wait),
`endif
    .bus            (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [15:0] t;
    t = {2'b00, a};
    return (t * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // ROM model: address registered on rom_rd, data available for the arbiter to sample
  // ROM_LAT edges after rom_rd rises; garbage when no read was issued.
  always @(posedge clock)
    bus.rom_q <= bus.rom_rd ? rom_word(bus.rom_addr) : DATA_W'($urandom);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                m_cyc    = 0;
  bit                m_armed  = 1'b0;
  bit                m_force  = 1'b0;
  int                m_wait   = 0;
  bit                m_rd     = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  bit                m_pv = 1'b0, m_sv = 1'b0;
  logic [DATA_W-1:0] m_pdata = '0, m_sdata = '0;
  bit                last_pg = 1'b0, last_sg = 1'b0;
  ret_t              pend[$];

  always @(negedge clock) begin
    bit pg, sg;
    ret_t r;
    if (m_armed) begin
      check("rom_rd",    bus.rom_rd,    m_rd);
      check("rom_addr",  bus.rom_addr,  m_addr);
      check("ppu_valid", bus.ppu_valid, m_pv);
      check("sm_valid",  bus.sm_valid,  m_sv);
      check("ppu_data",  bus.ppu_data,  m_pdata);
      check("sm_data",   bus.sm_data,   m_sdata);
    end
    pg = 1'b0;
    sg = 1'b0;
    if (!reset) begin
      if (m_force) sg = bus.sm_req;
      else begin
        pg = bus.ppu_req;
        sg = bus.sm_req && !bus.ppu_req;
      end
    end
    if (m_armed) begin
      check("ppu_gnt", bus.ppu_gnt, pg);
      check("sm_gnt",  bus.sm_gnt,  sg);
    end
    last_pg = pg;
    last_sg = sg;
    if (reset) begin
      m_armed = 1'b1;
      m_force = 1'b0;
      m_wait  = 0;
      m_rd    = 1'b0;
      m_addr  = '0;
      m_pv    = 1'b0;
      m_sv    = 1'b0;
      m_pdata = '0;
      m_sdata = '0;
      pend.delete();
    end else begin
      m_rd = pg || sg;
      if (pg) m_addr = bus.ppu_addr;
      else if (sg) m_addr = bus.sm_addr;
      if (pg || sg) begin
        r.due   = m_cyc + ROM_LAT + 1;
        r.owner = sg;
        r.data  = rom_word(m_addr);
        pend.push_back(r);
      end
      if (bus.sm_req && !sg) m_wait = (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
      else m_wait = 0;
      m_force = !m_force && (m_wait == STARVE_MAX);
      m_pv = 1'b0;
      m_sv = 1'b0;
      if (pend.size() > 0 && pend[0].due == m_cyc + 1) begin
        r = pend.pop_front();
        if (r.owner) begin m_sv = 1'b1; m_sdata = r.data; end
        else         begin m_pv = 1'b1; m_pdata = r.data; end
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit pr, input logic [ADDR_W-1:0] pa,
                       input bit sr, input logic [ADDR_W-1:0] sa);
    @(posedge clock);
    #1;
    reset        = rst;
    bus.ppu_req  = pr;
    bus.ppu_addr = pa;
    bus.sm_req   = sr;
    bus.sm_addr  = sa;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.ppu_req  = 1'b0;
    bus.ppu_addr = '0;
    bus.sm_req   = 1'b0;
    bus.sm_addr  = '0;

    // Single ppu read after reset
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    @(negedge clock);
    check("rst_rom_rd",   bus.rom_rd,   0);
    check("rst_ppu_data", bus.ppu_data, 0);
    drive(1'b0, 1'b1, 14'h0010, 1'b0, '0);
    @(negedge clock);
    check("s1_gnt", bus.ppu_gnt, 1);
    idle(1);
    @(negedge clock);
    check("s1_rom_rd",   bus.rom_rd,   1);
    check("s1_rom_addr", bus.rom_addr, 32'h0010);
    idle(2);
    @(negedge clock);
    check("s1_valid",    bus.ppu_valid, 1);
    check("s1_data",     bus.ppu_data,  rom_word(14'h0010));
    check("s1_sm_valid", bus.sm_valid,  0);
    idle(4);

    // Continuous contention: 8 ppu grants then one forced sm grant, repeating
    for (int i = 0; i < 27; i++) begin
      drive(1'b0, 1'b1, ADDR_W'(14'h0100 + i), 1'b1, 14'h0200);
      @(negedge clock);
      check("s2_sm_slot",  bus.sm_gnt,  (i % 9) == 8);
      check("s2_ppu_slot", bus.ppu_gnt, (i % 9) != 8);
    end
    idle(4);
    check("s2_sm_data", bus.sm_data, rom_word(14'h0200));

    // Alternating single requests: returns in order on consecutive cycles
    drive(1'b0, 1'b1, 14'h0001, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 14'h0002);
    drive(1'b0, 1'b1, 14'h0003, 1'b0, '0);
    idle(1);
    @(negedge clock);
    check("s3_ret0", bus.ppu_valid, 1);
    check("s3_dat0", bus.ppu_data,  rom_word(14'h0001));
    idle(1);
    @(negedge clock);
    check("s3_ret1", bus.sm_valid, 1);
    check("s3_dat1", bus.sm_data,  rom_word(14'h0002));
    idle(1);
    @(negedge clock);
    check("s3_ret2", bus.ppu_valid, 1);
    check("s3_dat2", bus.ppu_data,  rom_word(14'h0003));
    idle(3);

    // Reset with an sm read in flight
    drive(1'b0, 1'b0, '0, 1'b1, 14'h0005);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);
    @(negedge clock);
    check("s4_rom_rd",   bus.rom_rd,   0);
    check("s4_rom_addr", bus.rom_addr, 0);
    check("s4_sm_data",  bus.sm_data,  0);
    check("s4_ppu_data", bus.ppu_data, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      @(negedge clock);
      check("s4_no_sm_valid", bus.sm_valid, 0);
    end

    // sm drops its request in the forced cycle
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, ADDR_W'(14'h0300 + i), 1'b1, 14'h0400);
    drive(1'b0, 1'b1, 14'h0308, 1'b0, '0);
    @(negedge clock);
    check("s5_no_ppu_gnt", bus.ppu_gnt, 0);
    check("s5_no_sm_gnt",  bus.sm_gnt,  0);
    drive(1'b0, 1'b1, 14'h0308, 1'b0, '0);
    @(negedge clock);
    check("s5_rom_rd_off", bus.rom_rd,  0);
    check("s5_normal_gnt", bus.ppu_gnt, 1);
    idle(4);

    // Random traffic; requests held until granted (occasionally withdrawn), rare resets
    for (int i = 0; i < 1500; i++) begin
      bit rst, pr, sr;
      logic [ADDR_W-1:0] pa, sa;
      rst = ($urandom_range(199) == 0);
      pa  = bus.ppu_addr;
      sa  = bus.sm_addr;
      if (bus.ppu_req && !last_pg && $urandom_range(9) != 0) pr = 1'b1;
      else begin
        pr = ($urandom_range(9) < 6);
        pa = ADDR_W'($urandom);
      end
      if (bus.sm_req && !last_sg && $urandom_range(9) != 0) sr = 1'b1;
      else begin
        sr = ($urandom_range(9) < 5);
        sa = ADDR_W'($urandom);
      end
      drive(rst, pr, pa, sr, sa);
    end
    idle(6);

`ifdef ROM_ARB_STATS_EN
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 18; i++) drive(1'b0, 1'b1, ADDR_W'(i), 1'b1, 14'h0200);
    idle(1);
    @(negedge clock);
    check("stat_ppu_cnt",   stat_ppu_cnt,   16);
    check("stat_sm_cnt",    stat_sm_cnt,    2);
    check("stat_force_cnt", stat_force_cnt, 2);
    check("stat_max_wait",  stat_max_wait,  8);
    idle(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
